// File: rtl/multiplier_arbiter_if.sv
// ==========================================================================
// multiplier_arbiter_if: request, result and multiplier-side signals of the arbiter
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface multiplier_arbiter_if #(
  parameter int WIDTH = 32
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_signed;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_signed;
  logic               req1_ready;

  logic               res0_valid;
  logic [2*WIDTH-1:0] res0_data;
  logic               res0_err;
  logic               res0_ack;
  logic               res1_valid;
  logic [2*WIDTH-1:0] res1_data;
  logic               res1_err;
  logic               res1_ack;

  logic               mul_restart;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_ready;
  logic [2*WIDTH-1:0] mul_out;
  logic               busy;

  // Requesters and the multiplier instance together form the master side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_signed,
    output req1_valid, req1_a, req1_b, req1_signed,
    output res0_ack, res1_ack, mul_ready, mul_out,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_data, res0_err,
    input  res1_valid, res1_data, res1_err,
    input  mul_restart, mul_a, mul_b, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed,
    input  req1_valid, req1_a, req1_b, req1_signed,
    input  res0_ack, res1_ack, mul_ready, mul_out,
    output req0_ready, req1_ready,
    output res0_valid, res0_data, res0_err,
    output res1_valid, res1_data, res1_err,
    output mul_restart, mul_a, mul_b, busy
  );
endinterface

`default_nettype wire

// File: rtl/multiplier_arbiter.sv
// ==========================================================================
// multiplier_arbiter: round-robin sharing of one unsigned shift-add multiplier
// Revision: 1.0
// ==========================================================================
`default_nettype none

module multiplier_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  wire logic           clk,
  input  wire logic           reset,
  multiplier_arbiter_if.slave bus
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_rr;
  logic               r_owner;
  logic               r_neg;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic               r_restart;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_res_valid;
  logic [2*WIDTH-1:0] r_res_data;
  logic               r_res_err;

  logic               w_grant_any;
  logic               w_grant_sel;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_sel_signed;
  logic               w_owner_ack;
  logic [2*WIDTH-1:0] w_product;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_sel = 1'b0;
    if (reset && (r_state == S_IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant_any = 1'b1;
        w_grant_sel = r_rr;
      end else if (bus.req0_valid) begin
        w_grant_any = 1'b1;
      end else if (bus.req1_valid) begin
        w_grant_any = 1'b1;
        w_grant_sel = 1'b1;
      end
    end
  end

  assign w_sel_a      = w_grant_sel ? bus.req1_a      : bus.req0_a;
  assign w_sel_b      = w_grant_sel ? bus.req1_b      : bus.req0_b;
  assign w_sel_signed = w_grant_sel ? bus.req1_signed : bus.req0_signed;
  assign w_owner_ack  = r_owner ? bus.res1_ack : bus.res0_ack;
  assign w_product    = r_neg ? ((~bus.mul_out) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : bus.mul_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_neg       <= 1'b0;
      r_a_mag     <= '0;
      r_b_mag     <= '0;
      r_restart   <= 1'b0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_owner   <= w_grant_sel;
            r_neg     <= w_sel_signed & (w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1]);
            r_a_mag   <= magnitude(w_sel_a, w_sel_signed);
            r_b_mag   <= magnitude(w_sel_b, w_sel_signed);
            r_rr      <= ~w_grant_sel;
            r_restart <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_ready) begin
            r_res_data  <= w_product;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
            r_res_data  <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (w_owner_ack) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = w_grant_any & ~w_grant_sel;
  assign bus.req1_ready  = w_grant_any &  w_grant_sel;
  assign bus.res0_valid  = r_res_valid & ~r_owner;
  assign bus.res1_valid  = r_res_valid &  r_owner;
  assign bus.res0_data   = bus.res0_valid ? r_res_data : '0;
  assign bus.res1_data   = bus.res1_valid ? r_res_data : '0;
  assign bus.res0_err    = bus.res0_valid & r_res_err;
  assign bus.res1_err    = bus.res1_valid & r_res_err;
  assign bus.mul_restart = r_restart;
  assign bus.mul_a       = r_a_mag;
  assign bus.mul_b       = r_b_mag;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
// ==========================================================================
// tb_multiplier_arbiter: vector table, random ops and corner sequences for the arbiter
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_multiplier_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic mul_en = 1'b1;
  int   mul_cnt = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiplier_arbiter_if #(.WIDTH(WIDTH)) bus ();

  multiplier_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for the shift-add unit: one-cycle done pulse WIDTH cycles after restart.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt       <= 0;
      bus.mul_ready <= 1'b0;
      bus.mul_out   <= '0;
    end else if (bus.mul_restart) begin
      mul_cnt       <= WIDTH;
      bus.mul_ready <= 1'b0;
      bus.mul_out   <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
    end else if (mul_cnt != 0) begin
      mul_cnt       <= mul_cnt - 1;
      bus.mul_ready <= (mul_cnt == 1) && mul_en;
    end else begin
      bus.mul_ready <= 1'b0;
    end
  end

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_signed = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_signed = s;
    end
  endtask

  task automatic set_ack(input int p, input logic v);
    if (p == 0) bus.res0_ack = v;
    else        bus.res1_ack = v;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvalid(input int p);
    return (p == 0) ? bus.res0_valid : bus.res1_valid;
  endfunction

  function automatic logic [63:0] rdata(input int p);
    return (p == 0) ? bus.res0_data : bus.res1_data;
  endfunction

  function automatic logic rerr(input int p);
    return (p == 0) ? bus.res0_err : bus.res1_err;
  endfunction

  // Called at a negedge with the request already driven; returns at the first negedge after accept.
  task automatic wait_grant(input int p, input bit keep);
    int n;
    n = 0;
    #1;
    while (!rdy(p) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL grant_timeout: port %0d never ready", p);
    end
    @(negedge clk);
    if (!keep) set_req(p, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_result(input int p, output logic [63:0] d, output logic e, output int lat);
    lat = 1;
    while (!rvalid(p) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) begin
      total++; bad++;
      $display("FAIL result_timeout: port %0d no result", p);
    end
    d = rdata(p);
    e = rerr(p);
  endtask

  task automatic do_ack(input int p);
    set_ack(p, 1'b1);
    @(negedge clk);
    set_ack(p, 1'b0);
    check("valid_drop", {63'b0, rvalid(p)}, 64'd0);
    check("data_zero_idle", rdata(p), 64'd0);
  endtask

  task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] d, output logic e, output int lat);
    @(negedge clk);
    set_req(p, 1'b1, a, b, s);
    wait_grant(p, 1'b0);
    wait_result(p, d, e, lat);
    do_ack(p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;
    int          g;
    int          exp_owner;
    int          n;
    logic [31:0] ra, rb;
    logic        rs;
    int          rp;

    tbl[0] = '{0, 32'd7,         32'd6,         1'b0, 64'd42};
    tbl[1] = '{1, 32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[2] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[4] = '{0, 32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000};
    tbl[5] = '{1, 32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0};
    tbl[6] = '{0, 32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000};
    tbl[7] = '{1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};

    bus.res0_ack = 1'b0;
    bus.res1_ack = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd4, 1'b0);
    set_req(1, 1'b1, 32'd5, 32'd6, 1'b0);
    repeat (3) @(negedge clk);

    check("rst_ready0",  {63'b0, bus.req0_ready},  64'd0);
    check("rst_ready1",  {63'b0, bus.req1_ready},  64'd0);
    check("rst_busy",    {63'b0, bus.busy},        64'd0);
    check("rst_valid0",  {63'b0, bus.res0_valid},  64'd0);
    check("rst_valid1",  {63'b0, bus.res1_valid},  64'd0);
    check("rst_restart", {63'b0, bus.mul_restart}, 64'd0);
    check("rst_mul_a",   {32'b0, bus.mul_a},       64'd0);
    check("rst_mul_b",   {32'b0, bus.mul_b},       64'd0);
    check("rst_data0",   bus.res0_data,            64'd0);

    // Continuous contention straight out of reset: grants alternate from req0.
    reset = 1'b1;
    exp_owner = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("grant_order", {62'b0, bus.req1_ready, bus.req0_ready},
            (exp_owner == 1) ? 64'd2 : 64'd1);
      g = bus.req1_ready ? 1 : 0;
      @(negedge clk);
      wait_result(g, d, e, lat);
      check("contention_data", d, (exp_owner == 1) ? 64'd30 : 64'd12);
      do_ack(g);
      exp_owner = 1 - exp_owner;
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].s, d, e, lat);
      check("vec_data", d, tbl[i].exp);
      check("vec_err", {63'b0, e}, 64'd0);
      if (i == 0) check("latency", 64'(lat), 64'(WIDTH + 3));
    end

    for (int i = 0; i < 24; i++) begin
      rp = int'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 3) ra = 32'h8000_0000;
      do_op(rp, ra, rb, rs, d, e, lat);
      check("rand_data", d, ref_mul(ra, rb, rs));
    end

    // Result held while ack is withheld; the other requester is locked out.
    @(negedge clk);
    set_req(0, 1'b1, 32'd9, 32'd9, 1'b0);
    wait_grant(0, 1'b0);
    wait_result(0, d, e, lat);
    set_req(1, 1'b1, 32'd2, 32'd3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("hold_data", bus.res0_data, 64'd81);
      check("hold_valid_ready1", {62'b0, bus.res0_valid, bus.req1_ready}, 64'd2);
    end
    do_ack(0);
    wait_grant(1, 1'b0);
    wait_result(1, d, e, lat);
    check("after_hold_data", d, 64'd6);
    do_ack(1);

    // Stray ack during the operation must not consume the later result.
    @(negedge clk);
    set_req(1, 1'b1, 32'd11, 32'd13, 1'b0);
    set_ack(1, 1'b1);
    wait_grant(1, 1'b0);
    repeat (5) @(negedge clk);
    set_ack(1, 1'b0);
    wait_result(1, d, e, lat);
    @(negedge clk);
    check("stray_ack_valid", {63'b0, bus.res1_valid}, 64'd1);
    check("stray_ack_data", bus.res1_data, 64'd143);
    do_ack(1);

    mul_en = 1'b0;
    do_op(0, 32'd5, 32'd5, 1'b0, d, e, lat);
    check("timeout_err", {63'b0, e}, 64'd1);
    check("timeout_data", d, 64'd0);
    check("timeout_latency", 64'(lat), 64'(TIMEOUT + 2));
    mul_en = 1'b1;

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    set_req(1, 1'b1, 32'd100, 32'd200, 1'b1);
    wait_grant(1, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy",   {63'b0, bus.busy},       64'd0);
    check("midrst_valid1", {63'b0, bus.res1_valid}, 64'd0);
    check("midrst_mul_a",  {32'b0, bus.mul_a},      64'd0);
    check("midrst_mul_b",  {32'b0, bus.mul_b},      64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(1, 32'hFFFF_FFF9, 32'd9, 1'b1, d, e, lat);
    check("post_rst_data", d, ref_mul(32'hFFFF_FFF9, 32'd9, 1'b1));
    check("post_rst_err", {63'b0, e}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
